id_stage_pipe: RTL

- Parametrised, registered successor to the combinational decode stage.
- Decodes one instruction per cycle from IF/ID into a registered ID/EX payload, with valid/ready handshakes on both sides.
- Contains a per-register pending-write scoreboard that stalls on RAW/WAW hazards and a flush input for branch redirect.
- Sits between if_id and ex; reads the register file combinationally.

---
 rtl/id_stage_pipe.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered instruction-decode stage between IF/ID and EX.
// Decodes one instruction per cycle into a registered ID/EX payload with
// valid/ready handshakes on both sides, tracks in-flight register writes in a
// pending-write scoreboard and stalls on RAW/WAW hazards. flush_i kills the
// registered payload on a branch redirect.
// Optional build macro: ID_WB_BYPASS_EN -- when defined, a source register
// retiring on the writeback port this cycle is forwarded from wb_data_i
// instead of stalling.
module id_stage_pipe #(
  parameter int ILEN    = 16,
  parameter int XLEN    = 16,
  parameter int IADDR_W = 4,
  parameter int OPC_W   = 4,
  parameter int RAW     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  // IF/ID side
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ILEN-1:0]    inst_i,
  input  logic [IADDR_W-1:0] inst_addr_i,
  // register file read port (combinational)
  output logic [RAW-1:0]     rs1_addr_o,
  output logic [RAW-1:0]     rs2_addr_o,
  input  logic [XLEN-1:0]    rs1_i,
  input  logic [XLEN-1:0]    rs2_i,
  // ID/EX side
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ILEN-1:0]    inst_o,
  output logic [IADDR_W-1:0] inst_addr_o,
  output logic [XLEN-1:0]    op1_o,
  output logic [XLEN-1:0]    op2_o,
  output logic [RAW-1:0]     rd_addr_o,
  output logic               reg_wen_o,
  // redirect and writeback
  input  logic               flush_i,
  input  logic               wb_valid_i,
  input  logic [RAW-1:0]     wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i
);

  localparam int NREG  = 2 ** RAW;
  localparam int IMM_W = ILEN - OPC_W - RAW;

  // Opcode encodings shared with the rest of the core
  localparam logic [OPC_W-1:0] NOP_OP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] ADDI_OP = OPC_W'(1);
  localparam logic [OPC_W-1:0] BNE_OP  = OPC_W'(2);
  localparam logic [OPC_W-1:0] BLT_OP  = OPC_W'(3);

  // ---------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------
  logic [OPC_W-1:0] opcode;
  logic [RAW-1:0]   f_rd;
  logic [RAW-1:0]   f_rs;
  logic [IMM_W-1:0] f_imm;

  assign opcode = inst_i[OPC_W-1:0];
  assign f_rd   = inst_i[OPC_W+RAW-1:OPC_W];
  assign f_rs   = inst_i[OPC_W+2*RAW-1:OPC_W+RAW];
  assign f_imm  = inst_i[ILEN-1:OPC_W+RAW];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic               out_valid_q;
  logic [ILEN-1:0]    inst_q;
  logic [IADDR_W-1:0] inst_addr_q;
  logic [XLEN-1:0]    op1_q;
  logic [XLEN-1:0]    op2_q;
  logic [RAW-1:0]     rd_addr_q;
  logic               reg_wen_q;
  logic [NREG-1:0]    pend_q;
  logic [NREG-1:0]    pend_d;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [RAW-1:0] dec_rs1;
  logic [RAW-1:0] dec_rs2;
  logic           rd1_used;
  logic           rd2_used;
  logic           op2_is_imm;
  logic           dec_wen;
  logic [RAW-1:0] dec_rd;

  // Classify the opcode: which sources are read, whether it writes rd
  always_comb begin
    dec_rs1    = '0;
    dec_rs2    = '0;
    rd1_used   = 1'b0;
    rd2_used   = 1'b0;
    op2_is_imm = 1'b0;
    dec_wen    = 1'b0;
    dec_rd     = '0;
    case (opcode)
      ADDI_OP: begin
        dec_rs1    = f_rd;
        rd1_used   = 1'b1;
        op2_is_imm = 1'b1;
        dec_wen    = 1'b1;
        dec_rd     = f_rd;
      end
      NOP_OP: begin
        // reads nothing, writes nothing
      end
      BNE_OP, BLT_OP: begin
        dec_rs1  = f_rd;
        dec_rs2  = f_rs;
        rd1_used = 1'b1;
        rd2_used = 1'b1;
      end
      default: begin
        dec_rs1  = f_rd;
        dec_rs2  = f_rs;
        rd1_used = 1'b1;
        rd2_used = 1'b1;
        dec_wen  = 1'b1;
        dec_rd   = f_rd;
      end
    endcase
  end

  assign rs1_addr_o = dec_rs1;
  assign rs2_addr_o = dec_rs2;

  // ---------------------------------------------------------------------
  // Scoreboard and hazard detection, one slice per architectural register
  // ---------------------------------------------------------------------
  logic            consume;
  logic [NREG-1:0] haz_vec;
  logic [NREG-1:0] byp_vec;
  logic [NREG-1:0] pend_set;
  logic [NREG-1:0] pend_clr;
  logic            hazard;
  logic            accept;

  assign consume = out_valid_q & out_ready_i;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic read_hit;
    logic out_hit;

    // Only registers the instruction actually reads can stall it
    assign read_hit = (rd1_used & (dec_rs1 == RAW'(gi)))
                    | (rd2_used & (dec_rs2 == RAW'(gi)));
    // The payload sitting in the output register will write this register
    // once consumed; its value cannot be forwarded from anywhere.
    assign out_hit  = out_valid_q & reg_wen_q & (rd_addr_q == RAW'(gi));

    assign pend_clr[gi] = wb_valid_i & (wb_rd_i == RAW'(gi));
    assign pend_set[gi] = consume & reg_wen_q & (rd_addr_q == RAW'(gi));

`ifdef ID_WB_BYPASS_EN
    // Retiring this cycle: the value is on wb_data_i, no need to wait
    assign byp_vec[gi] = pend_q[gi] & pend_clr[gi];
`else
    assign byp_vec[gi] = 1'b0;
`endif

    assign haz_vec[gi] = read_hit & ((pend_q[gi] & ~byp_vec[gi]) | out_hit);

    // Set has priority over clear when both hit the same register
    assign pend_d[gi] = (pend_q[gi] & ~pend_clr[gi]) | pend_set[gi];
  end

  assign hazard     = |haz_vec;
  assign in_ready_o = ~hazard & (~out_valid_q | out_ready_i) & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;

  // ---------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op1_d;
  logic [XLEN-1:0] op2_d;

`ifdef ID_WB_BYPASS_EN
  assign rs1_val = byp_vec[dec_rs1] ? wb_data_i : rs1_i;
  assign rs2_val = byp_vec[dec_rs2] ? wb_data_i : rs2_i;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data_i;
  assign rs1_val = rs1_i;
  assign rs2_val = rs2_i;
`endif

  assign op1_d = rd1_used ? rs1_val : '0;
  assign op2_d = op2_is_imm ? XLEN'(f_imm) : (rd2_used ? rs2_val : '0);

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------

  // Output valid: flush kills, accept loads, consume without refill drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // Payload loads only on accept, so it holds while EX back-pressures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= '0;
      inst_addr_q <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_addr_q   <= '0;
      reg_wen_q   <= 1'b0;
    end else if (accept) begin
      inst_q      <= inst_i;
      inst_addr_q <= inst_addr_i;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_addr_q   <= dec_rd;
      reg_wen_q   <= dec_wen;
    end
  end

  // Pending-write scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign inst_o      = inst_q;
  assign inst_addr_o = inst_addr_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign rd_addr_o   = rd_addr_q;
  assign reg_wen_o   = reg_wen_q;

endmodule
